// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: controller state
// encoding, physical address width and the segment:offset address helper.
package prefetch_queue_pkg;

    // Width of a real-mode physical byte address.
    localparam int PHYS_ADDR_W = 20;

    // Controller states. DISCARD waits out a bus cycle whose data is stale.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } pq_state_t;

    // Segment base (cs * 16) plus offset, wrapping at 1 MiB.
    function automatic logic [PHYS_ADDR_W-1:0] phys_addr(input logic [15:0] seg,
                                                         input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

endpackage

// File: rtl/prefetch_queue_byte_fifo.sv
// byte_fifo: circular byte buffer with a 1-or-2-byte write port (low byte
// written first), a registered 1-byte read port and a flush input.
// Handshake: a write is taken when wr_en=1 and enough space is free; a read
// is taken when rd_en=1 and the buffer is not empty; rd_data updates at the
// edge that takes the read and holds otherwise. flush overrides both.
module byte_fifo #(
    parameter int DEPTH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic                         wr_two,
    input  logic [15:0]                  wr_data,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] space;
    logic [CNT_W-1:0] wr_n;
    logic             push_ok;
    logic             pop_ok;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Accept decisions are based on the registered count only.
    always_comb begin
        space   = CNT_W'(DEPTH) - count;
        wr_n    = wr_two ? CNT_W'(2) : CNT_W'(1);
        push_ok = wr_en && (space >= wr_n);
        pop_ok  = rd_en && (count != '0);
        empty   = (count == '0);
    end

    // Storage, pointers, occupancy and registered read byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= 8'h00;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data[7:0];
                if (wr_two) begin
                    mem[wrap_inc(wr_ptr)] <= wr_data[15:8];
                    wr_ptr <= wrap_inc(wrap_inc(wr_ptr));
                end else begin
                    wr_ptr <= wrap_inc(wr_ptr);
                end
            end
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= wrap_inc(rd_ptr);
            end
            count <= count + (push_ok ? wr_n : '0) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetcher. Fetches code bytes from cs:fetch_ip
// over a simple request/ack bus into a byte queue, restarting on branches.
// Bus handshake: mem_access rises with a stable mem_address/mem_bytesel and
// stays high until the single-cycle mem_ack; mem_data is valid with mem_ack.
// Build option: define PREFETCH_WORD_FETCH_EN for 16-bit word fetches;
// otherwise every fetch is a single byte.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    output logic        mem_access,
    input  logic        mem_ack,
    output logic [18:0] mem_address,
    output logic [1:0]  mem_bytesel,
    input  logic [15:0] mem_data,
    input  logic        fifo_rd_en,
    output logic [7:0]  fifo_rd_data,
    output logic        fifo_empty,
    output pq_state_t   state_dbg
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
`ifdef PREFETCH_WORD_FETCH_EN
    localparam int FETCH_NEED = 2;
`else
    localparam int FETCH_NEED = 1;
`endif

    pq_state_t              state_q;
    pq_state_t              state_d;
    logic [15:0]            fetch_ip_q;
    logic [15:0]            fetch_ip_d;
    logic                   launch;
    logic                   push_en;
    logic                   push_two;
    logic [15:0]            push_data;
    logic [1:0]             launch_bytesel;
    logic [PHYS_ADDR_W-1:0] launch_addr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       free_slots;
    logic                   fetch_odd;

    // fetch_ip cannot change while a request is live without the data being
    // dropped, so its bit 0 still describes the outstanding request at ack.
    assign fetch_odd   = fetch_ip_q[0];
    assign launch_addr = phys_addr(cs, fetch_ip_q);
    assign free_slots  = CNT_W'(QUEUE_DEPTH) - count;
    assign state_dbg   = state_q;

`ifdef PREFETCH_WORD_FETCH_EN
    assign launch_bytesel = fetch_odd ? 2'b10 : 2'b11;
    assign push_two       = !fetch_odd;
`else
    assign launch_bytesel = fetch_odd ? 2'b10 : 2'b01;
    assign push_two       = 1'b0;
`endif

    // Odd address: the wanted byte arrives on the high lane; move it low.
    assign push_data = fetch_odd ? {8'h00, mem_data[15:8]} : mem_data;

    // Next state, launch and push decisions; load_new_ip overrides a push.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        push_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!load_new_ip && (free_slots >= CNT_W'(FETCH_NEED))) begin
                    state_d = FETCH;
                    launch  = 1'b1;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    push_en = !load_new_ip;
                end else if (load_new_ip) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch pointer: branch target wins, otherwise advance by bytes pushed.
    always_comb begin
        fetch_ip_d = fetch_ip_q;
        if (load_new_ip) begin
            fetch_ip_d = new_ip;
        end else if (push_en) begin
            fetch_ip_d = fetch_ip_q + (push_two ? 16'd2 : 16'd1);
        end
    end

    // State, fetch pointer and registered bus request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_ip_q  <= 16'h0000;
            mem_access  <= 1'b0;
            mem_address <= '0;
            mem_bytesel <= 2'b00;
        end else begin
            state_q    <= state_d;
            fetch_ip_q <= fetch_ip_d;
            if (launch) begin
                mem_access  <= 1'b1;
                mem_address <= launch_addr[PHYS_ADDR_W-1:1];
                mem_bytesel <= launch_bytesel;
            end else if (mem_ack && (state_q != IDLE)) begin
                mem_access <= 1'b0;
            end
        end
    end

    byte_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (load_new_ip),
        .wr_en   (push_en),
        .wr_two  (push_two),
        .wr_data (push_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (count)
    );

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter QUEUE_DEPTH, default 6: byte capacity of the instruction queue.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cs  input  16  code segment, sampled when each fetch is launched.
REQ-005 new_ip  input  16  branch target offset.
REQ-006 load_new_ip  input  1  flush queue, restart fetch at new_ip.
REQ-007 mem_access  output  1  bus request, held until mem_ack.
REQ-008 mem_ack  input  1  one-cycle completion strobe.
REQ-009 mem_address  output  19  physical word address [19:1].
REQ-010 mem_bytesel  output  2  byte enables, [0]=low byte.
REQ-011 mem_data  input  16  read data, valid with mem_ack.
REQ-012 fifo_rd_en  input  1  consumer pop request.
REQ-013 fifo_rd_data  output  8  popped byte, registered.
REQ-014 fifo_empty  output  1  queue holds no bytes.

Function
REQ-015 Physical address SHALL be ({cs,4'b0} + {4'b0,fetch_ip}) modulo 2^20; fetch_ip SHALL wrap at 16 bits.
REQ-016 FSM states: IDLE, FETCH, DISCARD.
REQ-017 IDLE->FETCH when load_new_ip=0 and free slots >= 2; mem_access SHALL assert the cycle after entry and drive a stable mem_address/mem_bytesel until mem_ack.
REQ-018 FETCH->IDLE on mem_ack; even address: push mem_data[7:0] then mem_data[15:8], fetch_ip += 2; odd address: bytesel=2'b10, push mem_data[15:8] only, fetch_ip += 1.
REQ-019 load_new_ip SHALL empty the queue at the next edge, load fetch_ip<=new_ip, and take priority over same-cycle push and pop.
REQ-020 load_new_ip in FETCH without mem_ack -> DISCARD; DISCARD holds mem_access until mem_ack, drops data, -> IDLE.
REQ-021 load_new_ip coincident with mem_ack: data dropped, -> IDLE.
REQ-022 Pop accepted when fifo_rd_en=1 and fifo_empty=0; fifo_rd_data SHALL take the head byte at the following edge and hold until the next accepted pop.
REQ-023 fifo_rd_en when empty SHALL be ignored; fifo_rd_data unchanged.
REQ-024 Same-cycle push and pop SHALL be legal; count_next = count + pushed - popped, never exceeding QUEUE_DEPTH.
REQ-025 fifo_empty SHALL be derived from registered count; a byte pushed at edge N is poppable from cycle N+1.
REQ-026 Queue SHALL return bytes in strictly ascending address order.

Reset
REQ-027 reset SHALL force: state IDLE, mem_access=0, count=0, fifo_empty=1, fifo_rd_data=8'h00, fetch_ip=16'h0000, mem_bytesel=2'b00.
REQ-028 reset during FETCH/DISCARD SHALL drop mem_access at the next edge; a later mem_ack SHALL be ignored.

Configuration
REQ-029 Macro PREFETCH_WORD_FETCH_EN: defined -> word fetches per REQ-017/018.
REQ-030 Undefined -> every fetch is single-byte (bytesel selects address bit 0), one byte pushed, fetch_ip += 1, launch requires free slots >= 1.

Structure
REQ-031 Shared package SHALL hold the state enum (IDLE/FETCH/DISCARD) and physical-address width constant (20).
REQ-032 Storage SHALL be sub-module byte_fifo (circular buffer, 1-or-2-byte write port, 1-byte read port, flush input); prefetch_queue holds FSM and address logic.

Verification
REQ-033 cs=16'hF000, new_ip=16'hFFF0 load; ack 16'hEAEB -> requests 20'hFFFF0 bytesel 2'b11, queue pops EB then EA, fetch_ip=16'hFFF2.
REQ-034 Odd target new_ip=16'h0101, cs=0, ack 16'h1234 -> bytesel 2'b10, address 20'h00100, single byte 12 queued, next request 20'h00102.
REQ-035 Fill with no pops -> six bytes queued, no 4th request, mem_access stays 0; one pop -> still no fetch (free=1); second pop -> fetch launches.
REQ-036 load_new_ip two cycles into FETCH, ack 3 cycles later -> DISCARD, data dropped, fifo_empty=1, next request at new_ip.
REQ-037 Push and pop same cycle with count=1 -> count=2 at next edge, popped byte correct.
REQ-038 reset asserted while mem_access=1 -> mem_access=0, fifo_empty=1, fifo_rd_data=00 next edge; stray mem_ack produces no push.
